// File: rtl/exmem_pipe_reg.sv
// EX/MEM pipeline register with valid bit, stall hold, flush bubble insertion
// and saturating stall/bubble performance counters.
module exmem_pipe_reg #(
  parameter int DATA_W            = 32,
  parameter int RADDR_W           = 5,
  parameter int WB_W              = 2,
  parameter int M_W               = 3,
  parameter int CNT_W             = 16,
  parameter int CLR_DATA_ON_FLUSH = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               cnt_clr,
  input  logic               EX_valid,
  input  logic [DATA_W-1:0]  EX_PCaddr,
  input  logic               EX_zf,
  input  logic [DATA_W-1:0]  EX_ALUres,
  input  logic [DATA_W-1:0]  EX_WrData,
  input  logic [RADDR_W-1:0] EX_RegWr,
  input  logic [WB_W-1:0]    EX_WB,
  input  logic [M_W-1:0]     EX_M,
  output logic               MEM_valid,
  output logic [DATA_W-1:0]  MEM_PCaddr,
  output logic               MEM_zf,
  output logic [DATA_W-1:0]  MEM_ALUres,
  output logic [DATA_W-1:0]  MEM_WrData,
  output logic [RADDR_W-1:0] MEM_RegWr,
  output logic [WB_W-1:0]    MEM_WB,
  output logic [M_W-1:0]     MEM_M,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic               valid_q,  valid_d;
  logic [DATA_W-1:0]  pc_q,     pc_d;
  logic               zf_q,     zf_d;
  logic [DATA_W-1:0]  alu_q,    alu_d;
  logic [DATA_W-1:0]  wdata_q,  wdata_d;
  logic [RADDR_W-1:0] regwr_q,  regwr_d;
  logic [WB_W-1:0]    wb_q,     wb_d;
  logic [M_W-1:0]     m_q,      m_d;
  logic [CNT_W-1:0]   stall_cnt_q,  stall_cnt_d;
  logic [CNT_W-1:0]   bubble_cnt_q, bubble_cnt_d;

  logic load;
  logic stall_inc;
  logic bubble_inc;

  assign load       = !flush && !stall;
  assign stall_inc  = stall && !flush;
  assign bubble_inc = flush || (load && !EX_valid);

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    zf_d    = zf_q;
    alu_d   = alu_q;
    wdata_d = wdata_q;
    regwr_d = regwr_q;
    wb_d    = wb_q;
    m_d     = m_q;
    if (flush) begin
      valid_d = 1'b0;
      zf_d    = 1'b0;
      regwr_d = '0;
      wb_d    = '0;
      m_d     = '0;
      if (CLR_DATA_ON_FLUSH != 0) begin
        pc_d    = '0;
        alu_d   = '0;
        wdata_d = '0;
      end
    end else if (load) begin
      valid_d = EX_valid;
      pc_d    = EX_PCaddr;
      zf_d    = EX_zf;
      alu_d   = EX_ALUres;
      wdata_d = EX_WrData;
      // An invalid slot must never carry write enables into MEM/WB.
      regwr_d = EX_valid ? EX_RegWr : '0;
      wb_d    = EX_valid ? EX_WB    : '0;
      m_d     = EX_valid ? EX_M     : '0;
    end
  end

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
    end else begin
      if (stall_inc && (stall_cnt_q != '1))
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      if (bubble_inc && (bubble_cnt_q != '1))
        bubble_cnt_d = bubble_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      zf_q         <= 1'b0;
      alu_q        <= '0;
      wdata_q      <= '0;
      regwr_q      <= '0;
      wb_q         <= '0;
      m_q          <= '0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      zf_q         <= zf_d;
      alu_q        <= alu_d;
      wdata_q      <= wdata_d;
      regwr_q      <= regwr_d;
      wb_q         <= wb_d;
      m_q          <= m_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign MEM_valid  = valid_q;
  assign MEM_PCaddr = pc_q;
  assign MEM_zf     = zf_q;
  assign MEM_ALUres = alu_q;
  assign MEM_WrData = wdata_q;
  assign MEM_RegWr  = regwr_q;
  assign MEM_WB     = wb_q;
  assign MEM_M      = m_q;
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_exmem_pipe_reg.sv
// Bench for exmem_pipe_reg: default instance A and a wide, CNT_W=4,
// clear-on-flush instance B driven from the same stimulus.
module tb_exmem_pipe_reg;

  typedef struct {
    logic        valid;
    logic [63:0] pc;
    logic        zf;
    logic [63:0] alu;
    logic [63:0] wd;
    logic [5:0]  rw;
    logic [1:0]  wb;
    logic [2:0]  m;
    int          sc;
    int          bc;
  } exp_t;

  logic clk, rst_n, stall, flush, cnt_clr;
  logic        ex_valid, ex_zf;
  logic [63:0] ex_pc, ex_alu, ex_wd;
  logic [5:0]  ex_rw;
  logic [1:0]  ex_wb;
  logic [2:0]  ex_m;

  logic        a_valid, a_zf;
  logic [31:0] a_pc, a_alu, a_wd;
  logic [4:0]  a_rw;
  logic [1:0]  a_wb;
  logic [2:0]  a_m;
  logic [15:0] a_sc, a_bc;

  logic        b_valid, b_zf;
  logic [63:0] b_pc, b_alu, b_wd;
  logic [5:0]  b_rw;
  logic [1:0]  b_wb;
  logic [2:0]  b_m;
  logic [3:0]  b_sc, b_bc;

  int errors = 0;
  int checks = 0;
  exp_t ma, mb;
  exp_t qa[$];
  exp_t qb[$];

  exmem_pipe_reg u_a (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .EX_valid(ex_valid), .EX_PCaddr(ex_pc[31:0]), .EX_zf(ex_zf),
    .EX_ALUres(ex_alu[31:0]), .EX_WrData(ex_wd[31:0]), .EX_RegWr(ex_rw[4:0]),
    .EX_WB(ex_wb), .EX_M(ex_m),
    .MEM_valid(a_valid), .MEM_PCaddr(a_pc), .MEM_zf(a_zf), .MEM_ALUres(a_alu),
    .MEM_WrData(a_wd), .MEM_RegWr(a_rw), .MEM_WB(a_wb), .MEM_M(a_m),
    .stall_cnt(a_sc), .bubble_cnt(a_bc)
  );

  exmem_pipe_reg #(.DATA_W(64), .RADDR_W(6), .CNT_W(4), .CLR_DATA_ON_FLUSH(1)) u_b (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .EX_valid(ex_valid), .EX_PCaddr(ex_pc), .EX_zf(ex_zf),
    .EX_ALUres(ex_alu), .EX_WrData(ex_wd), .EX_RegWr(ex_rw),
    .EX_WB(ex_wb), .EX_M(ex_m),
    .MEM_valid(b_valid), .MEM_PCaddr(b_pc), .MEM_zf(b_zf), .MEM_ALUres(b_alu),
    .MEM_WrData(b_wd), .MEM_RegWr(b_rw), .MEM_WB(b_wb), .MEM_M(b_m),
    .stall_cnt(b_sc), .bubble_cnt(b_bc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one stage for the current inputs.
  function automatic exp_t model(exp_t c, bit wide, int cmax);
    exp_t n;
    logic ld;
    n  = c;
    ld = !flush && !stall;
    if (flush) begin
      n.valid = 1'b0; n.zf = 1'b0; n.rw = '0; n.wb = '0; n.m = '0;
      if (wide) begin n.pc = '0; n.alu = '0; n.wd = '0; end
    end else if (ld) begin
      n.valid = ex_valid;
      n.zf    = ex_zf;
      n.pc    = wide ? ex_pc  : {32'h0, ex_pc[31:0]};
      n.alu   = wide ? ex_alu : {32'h0, ex_alu[31:0]};
      n.wd    = wide ? ex_wd  : {32'h0, ex_wd[31:0]};
      n.rw    = !ex_valid ? 6'd0 : (wide ? ex_rw : {1'b0, ex_rw[4:0]});
      n.wb    = ex_valid ? ex_wb : 2'd0;
      n.m     = ex_valid ? ex_m  : 3'd0;
    end
    if (cnt_clr) begin
      n.sc = 0; n.bc = 0;
    end else begin
      if (stall && !flush && c.sc < cmax) n.sc = c.sc + 1;
      if ((flush || (ld && !ex_valid)) && c.bc < cmax) n.bc = c.bc + 1;
    end
    return n;
  endfunction

  task automatic cmp_a();
    exp_t e;
    if (qa.size() == 0) begin
      checks++; errors++;
      $error("FAIL A.queue observed=empty expected=entry");
      return;
    end
    e = qa.pop_front();
    check("A.valid", 64'(a_valid), 64'(e.valid));
    check("A.pc",    64'(a_pc),    e.pc);
    check("A.zf",    64'(a_zf),    64'(e.zf));
    check("A.alu",   64'(a_alu),   e.alu);
    check("A.wd",    64'(a_wd),    e.wd);
    check("A.rw",    64'(a_rw),    64'(e.rw));
    check("A.wb",    64'(a_wb),    64'(e.wb));
    check("A.m",     64'(a_m),     64'(e.m));
    check("A.sc",    64'(a_sc),    64'(e.sc));
    check("A.bc",    64'(a_bc),    64'(e.bc));
  endtask

  task automatic cmp_b();
    exp_t e;
    if (qb.size() == 0) begin
      checks++; errors++;
      $error("FAIL B.queue observed=empty expected=entry");
      return;
    end
    e = qb.pop_front();
    check("B.valid", 64'(b_valid), 64'(e.valid));
    check("B.pc",    b_pc,         e.pc);
    check("B.zf",    64'(b_zf),    64'(e.zf));
    check("B.alu",   b_alu,        e.alu);
    check("B.wd",    b_wd,         e.wd);
    check("B.rw",    64'(b_rw),    64'(e.rw));
    check("B.wb",    64'(b_wb),    64'(e.wb));
    check("B.m",     64'(b_m),     64'(e.m));
    check("B.sc",    64'(b_sc),    64'(e.sc));
    check("B.bc",    64'(b_bc),    64'(e.bc));
  endtask

  task automatic step();
    ma = model(ma, 1'b0, 65535);
    mb = model(mb, 1'b1, 15);
    qa.push_back(ma);
    qb.push_back(mb);
    @(posedge clk);
    #1;
    cmp_a();
    cmp_b();
  endtask

  task automatic check_all_zero(string tag);
    check({tag, ".A.valid"}, 64'(a_valid), 64'd0);
    check({tag, ".A.pc"},    64'(a_pc),    64'd0);
    check({tag, ".A.alu"},   64'(a_alu),   64'd0);
    check({tag, ".A.rw"},    64'(a_rw),    64'd0);
    check({tag, ".A.wb"},    64'(a_wb),    64'd0);
    check({tag, ".A.m"},     64'(a_m),     64'd0);
    check({tag, ".A.zf"},    64'(a_zf),    64'd0);
    check({tag, ".A.wd"},    64'(a_wd),    64'd0);
    check({tag, ".A.sc"},    64'(a_sc),    64'd0);
    check({tag, ".A.bc"},    64'(a_bc),    64'd0);
    check({tag, ".B.pc"},    b_pc,         64'd0);
    check({tag, ".B.alu"},   b_alu,        64'd0);
    check({tag, ".B.valid"}, 64'(b_valid), 64'd0);
    check({tag, ".B.sc"},    64'(b_sc),    64'd0);
    check({tag, ".B.bc"},    64'(b_bc),    64'd0);
  endtask

  task automatic set_ex(logic v, logic [63:0] pc, logic [63:0] alu, logic [63:0] wd,
                        logic [5:0] rw, logic [1:0] wb, logic [2:0] m, logic zf);
    ex_valid = v; ex_pc = pc; ex_alu = alu; ex_wd = wd;
    ex_rw = rw; ex_wb = wb; ex_m = m; ex_zf = zf;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    set_ex(1'b0, '0, '0, '0, '0, '0, '0, 1'b0);
    ma = '{default: 0};
    mb = '{default: 0};
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst_init");
    @(negedge clk);
    rst_n = 1'b1;

    // Put nonzero state into both stages, then assert reset mid-cycle while stalled.
    set_ex(1'b1, 64'h0000_0000_0000_1000, 64'h10, 64'hAB, 6'd7, 2'b11, 3'b101, 1'b1);
    step();
    stall = 1'b1;
    step();
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    ma = '{default: 0};
    mb = '{default: 0};

    set_ex(1'b1, 64'h40, 64'h0000_0010, 64'h0, 6'd3, 2'b11, 3'b000, 1'b0);
    step();
    check("post_rst.alu",   64'(a_alu),   64'h10);
    check("post_rst.wb",    64'(a_wb),    64'h3);
    check("post_rst.valid", 64'(a_valid), 64'h1);

    set_ex(1'b1, 64'h44, 64'hDEAD_BEEF, 64'h55, 6'd4, 2'b01, 3'b010, 1'b0);
    step();
    stall = 1'b1;
    ex_alu = 64'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall.alu_hold", 64'(a_alu), 64'hDEAD_BEEF);
    end
    check("stall.cnt3", 64'(a_sc), 64'd3);
    stall = 1'b0;
    step();
    check("unstall.alu", 64'(a_alu), 64'h1234_5678);

    // Flush wins over stall; only B clears its data fields.
    stall = 1'b1; flush = 1'b1; ex_m = 3'b101;
    step();
    check("flush.valid", 64'(a_valid), 64'd0);
    check("flush.m",     64'(a_m),     64'd0);
    check("flush.wb",    64'(a_wb),    64'd0);
    check("flush.bc",    64'(a_bc),    64'd1);
    check("flush.sc",    64'(a_sc),    64'd3);
    check("flush.alu_a", 64'(a_alu),   64'h1234_5678);
    check("flush.alu_b", b_alu,        64'd0);
    stall = 1'b0; flush = 1'b0;

    set_ex(1'b0, 64'h48, 64'h99, 64'h77, 6'd7, 2'b11, 3'b111, 1'b1);
    step();
    check("inv.wb",    64'(a_wb),    64'd0);
    check("inv.rw",    64'(a_rw),    64'd0);
    check("inv.valid", 64'(a_valid), 64'd0);
    check("inv.bc",    64'(a_bc),    64'd2);
    check("inv.alu",   64'(a_alu),   64'h99);

    set_ex(1'b1, 64'hFFFF_0000_0000_0004, 64'h1, 64'h2, 6'd33, 2'b10, 3'b001, 1'b0);
    step();
    check("wide.pc_b", b_pc,        64'hFFFF_0000_0000_0004);
    check("wide.pc_a", 64'(a_pc),   64'h4);
    check("wide.rw_b", 64'(b_rw),   64'd33);

    stall = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("sat.sc_b", 64'(b_sc), 64'd15);
    cnt_clr = 1'b1;
    step();
    check("clr.sc_a", 64'(a_sc), 64'd0);
    check("clr.sc_b", 64'(b_sc), 64'd0);
    check("clr.pc_b", b_pc,      64'hFFFF_0000_0000_0004);
    cnt_clr = 1'b0;

    // Flush and clear together: the clear wins on the counters.
    stall = 1'b0; flush = 1'b1; cnt_clr = 1'b1;
    step();
    check("clr_flush.bc", 64'(a_bc), 64'd0);
    flush = 1'b0; cnt_clr = 1'b0;

    for (int i = 0; i < 60; i++) begin
      stall   = ($urandom_range(0, 9) < 3);
      flush   = ($urandom_range(0, 9) < 2);
      cnt_clr = ($urandom_range(0, 19) == 0);
      set_ex(($urandom_range(0, 3) != 0), {$urandom, $urandom}, {$urandom, $urandom},
             {$urandom, $urandom}, 6'($urandom), 2'($urandom), 3'($urandom), 1'($urandom));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exmem_pipe_reg.md
Name: exmem_pipe_reg

Overview:
Parametrised EX/MEM pipeline register for the MIPS pipeline, successor to the fixed-width EX/MEM latch. It adds a valid bit, a stall (hold) input, a flush (bubble-insert) input with control-field squashing, and saturating stall/bubble performance counters. It sits between the ALU/EX stage and the data-memory stage. It is driven by the hazard unit: stall on load-use, flush on taken branch.

Parameters:
DATA_W, 32, width of PCaddr, ALUres and WrData fields
RADDR_W, 5, destination register address width
WB_W, 2, write-back control field width
M_W, 3, memory-stage control field width
CNT_W, 16, width of each performance counter
CLR_DATA_ON_FLUSH, 0, 1 = data fields zeroed on flush; 0 = data fields hold

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold all stage outputs this cycle
flush  in  1  insert bubble this cycle
cnt_clr  in  1  synchronous clear of both counters
EX_valid  in  1  EX stage holds a real instruction
EX_PCaddr  in  DATA_W  branch target / PC from EX
EX_zf  in  1  ALU zero flag
EX_ALUres  in  DATA_W  ALU result
EX_WrData  in  DATA_W  store data
EX_RegWr  in  RADDR_W  destination register
EX_WB  in  WB_W  write-back controls
EX_M  in  M_W  memory controls
MEM_valid  out  1  registered valid
MEM_PCaddr, MEM_zf, MEM_ALUres, MEM_WrData, MEM_RegWr, MEM_WB, MEM_M  out  same widths as EX_*  registered fields
stall_cnt  out  CNT_W  cycles with stall=1 and flush=0
bubble_cnt  out  CNT_W  cycles a bubble entered the stage

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs, including both counters, are 0 immediately. This holds regardless of clk. Release is sampled at the next rising edge.
- Per rising edge, priority is reset > flush > stall > load.
- Flush (flush=1, overrides stall):
  - MEM_valid, MEM_WB, MEM_M, MEM_RegWr and MEM_zf become 0.
  - MEM_PCaddr, MEM_ALUres and MEM_WrData become 0 if CLR_DATA_ON_FLUSH=1; otherwise they hold.
  - bubble_cnt increments.
- Stall (stall=1, flush=0): every MEM_* output holds its value. stall_cnt increments.
- Load (stall=0, flush=0):
  - All MEM_* outputs take EX_* values; MEM_valid takes EX_valid.
  - If EX_valid=0, MEM_WB, MEM_M and MEM_RegWr are forced to 0 and bubble_cnt increments. The data fields still load.
- Latency: 1 cycle from EX_* to MEM_* on load. A stall adds exactly one cycle per stalled cycle.
- Invariant: MEM_valid=0 implies MEM_WB=0 and MEM_M=0. No memory write and no register write can ever leak from a bubble.
- Counters:
  - Unsigned, saturate at all-ones and never wrap.
  - cnt_clr=1 zeroes both counters on that edge, overriding any increment the same cycle. The pipeline fields are unaffected.
  - cnt_clr is independent of stall and flush.
- Simultaneous stall+flush: treated as a flush. bubble_cnt increments; stall_cnt does not.
- Reset asserted mid-stall or mid-flush: outputs clear immediately. No pending state survives; there is no internal state other than the output registers and counters.

Test Plan:
- Reset asserted between clock edges with outputs nonzero -> all outputs 0 before next edge. After release, a load of EX_ALUres=0x0000_0010, EX_WB=2'b11, EX_valid=1 -> MEM_ALUres=0x10, MEM_WB=2'b11, MEM_valid=1 after 1 edge.
- Load EX_ALUres=0xDEAD_BEEF, then stall=1 for 3 cycles while EX_ALUres=0x1234_5678 -> MEM_ALUres stays 0xDEADBEEF for 3 cycles, stall_cnt=3. Releasing stall -> 0x12345678 next edge.
- flush=1 with stall=1, EX_M=3'b101 -> MEM_valid=0, MEM_M=0, MEM_WB=0, bubble_cnt=1, stall_cnt unchanged. MEM_ALUres holds (CLR_DATA_ON_FLUSH=0) or reads 0 (CLR_DATA_ON_FLUSH=1 instance).
- Load with EX_valid=0, EX_WB=2'b11, EX_RegWr=5'd7 -> MEM_WB=0, MEM_RegWr=0, MEM_valid=0, bubble_cnt+1.
- CNT_W=4 instance, stall held 20 cycles -> stall_cnt saturates at 15. cnt_clr=1 with stall=1 on the same edge -> stall_cnt=0.
- DATA_W=64, RADDR_W=6 instance, load EX_PCaddr=0xFFFF_0000_0000_0004 -> MEM_PCaddr identical after 1 edge, no truncation.
